lzc_driver: RTL
===============

LZC_DRIVER -- requirements
Module: lzc_driver

Interface
REQ-001 Parameter WIDTH, default 8, LZC data width in bits.
REQ-002 Parameter DEPTH, default 16, entries in each of the instruction and golden FIFOs (power of 2).
REQ-003 Parameter DRAIN_CYC, default 8, idle cycles waited after the last instruction before finishing.
REQ-004 CLK  in  1  single clock, rising edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 START  in  1  one-cycle pulse to begin a replay run.
REQ-007 INSTR_WE  in  1  push INSTR_IN into the instruction FIFO.
REQ-008 INSTR_IN  in  WIDTH+2  micro-instruction {mode, ivalid, data[WIDTH-1:0]}.
REQ-009 GOLD_WE  in  1  push GOLD_IN into the golden FIFO.
REQ-010 GOLD_IN  in  9  expected zero count.
REQ-011 IVALID / MODE  out  1 / 1  drive the LZC inputs.
REQ-012 DATA  out  WIDTH  drives the LZC data input.
REQ-013 OVALID  in  1, ZEROS  in  9  LZC result returned to this block.
REQ-014 INSTR_FULL, GOLD_FULL  out  1  FIFO full flags.
REQ-015 BUSY  out  1  high in RUN or DRAIN.
REQ-016 DONE  out  1  high in DONE state.
REQ-017 MATCH_CNT, MISMATCH_CNT  out  11  result counters.
REQ-018 ERR  out  1  sticky; golden FIFO underflow seen.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; transitions occur only as stated in REQ-020 to REQ-022.
REQ-020 IDLE or DONE with START=1 -> RUN; MATCH_CNT, MISMATCH_CNT and ERR clear in the same edge; START in RUN or DRAIN is ignored.
REQ-021 In RUN, one instruction pops per cycle; the instruction FIFO empty at the pop decision -> DRAIN with a zeroed drain counter.
REQ-022 In DRAIN, the counter increments each cycle; at DRAIN_CYC-1 -> DONE; DONE holds until START.
REQ-023 Outputs are registered: the instruction popped at edge N appears on MODE/IVALID/DATA after edge N, i.e. 1-cycle latency.
REQ-024 Outside RUN, and in RUN with the FIFO empty, IVALID=0 and MODE/DATA hold their last values.
REQ-025 Instruction bit fields: bit WIDTH+1 -> MODE, bit WIDTH -> IVALID, bits WIDTH-1:0 -> DATA.
REQ-026 Checker is active in every state: on OVALID=1 at an edge, pop one golden entry.
REQ-027 Checker compare: if ZEROS==golden, increment MATCH_CNT; else increment MISMATCH_CNT.
REQ-028 OVALID with the golden FIFO empty: set ERR, increment MISMATCH_CNT, no pop.
REQ-029 Counters saturate at 2047 and never wrap.
REQ-030 A FIFO write while full is dropped, with no pointer change.
REQ-031 A simultaneous write and pop on a non-empty, non-full FIFO keeps occupancy unchanged.
REQ-032 A write to an empty FIFO is poppable the next cycle.
REQ-033 FIFO writes are accepted in every state, including RUN.
REQ-034 FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
REQ-035 Full = pointer MSBs differ and the rest are equal; empty = pointers equal.

Reset
REQ-036 RST_N low asynchronously forces IDLE and empties both FIFOs.
REQ-037 RST_N low asynchronously sets IVALID=0, MODE=0, DATA=0, MATCH_CNT=0, MISMATCH_CNT=0, ERR=0, BUSY=0, DONE=0.
REQ-038 Reset mid-RUN abandons the run; no partial state survives.
REQ-039 Normal operation resumes on the first rising edge after RST_N deasserts.

Structure
REQ-040 Shared package lzc_pkg holds the FSM state encoding (2 bits), counter width 11, ZEROS width 9 and the instruction field-position constants.
REQ-041 One sub-module, sync_fifo (parameters: width, depth), is instantiated twice, for instructions and golden values.

Verification
REQ-042 Load 3 instructions {0,1,8'h0F}, {1,1,8'h80}, {0,0,8'h00}, then START -> over 3 consecutive cycles IVALID=1,1,0 with DATA=0F,80,00; BUSY high; DONE after 3+DRAIN_CYC cycles.
REQ-043 Golden 4,0; OVALID with ZEROS=4 then ZEROS=1 -> MATCH_CNT=1, MISMATCH_CNT=1, ERR=0.
REQ-044 OVALID with the golden FIFO empty -> ERR=1, MISMATCH_CNT=1; ERR stays set until the next START.
REQ-045 Write 17 instructions with DEPTH=16 -> INSTR_FULL=1 after the 16th; the 17th is dropped; the run emits exactly 16 instructions.
REQ-046 2100 matching results -> MATCH_CNT saturates at 2047.
REQ-047 RST_N low during RUN, then START with an empty FIFO -> all outputs at reset values, then RUN -> DRAIN -> DONE with IVALID=0 throughout.

Source files
------------

// File: rtl/lzc_pkg.sv
// lzc_pkg: shared state encoding, widths and helpers for the LZC replay driver
package lzc_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int CNT_W      = 11;
  localparam int ZEROS_W    = 9;
  localparam int MODE_OFS   = 1;
  localparam int IVALID_OFS = 0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers; writes while full are dropped
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic push, pop;
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = wptr == rptr;
  assign push  = we && !full;
  assign pop   = re && !empty;
  assign rdata = mem[rptr[AW-1:0]];
  // pointer advance; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  // storage carries no reset; emptiness is defined by the pointers alone
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/lzc_driver.sv
// lzc_driver: replays queued micro-instructions into an LZC and scores its results against golden values
module lzc_driver import lzc_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int DRAIN_CYC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               instr_we,
  input  logic [WIDTH+1:0]   instr_in,
  input  logic               gold_we,
  input  logic [ZEROS_W-1:0] gold_in,
  output logic               ivalid,
  output logic               mode,
  output logic [WIDTH-1:0]   data,
  input  logic               ovalid,
  input  logic [ZEROS_W-1:0] zeros,
  output logic               instr_full,
  output logic               gold_full,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic               err
);
  localparam int MODE_BIT = WIDTH + MODE_OFS;
  localparam int IV_BIT   = WIDTH + IVALID_OFS;
  localparam int DW       = $clog2(DRAIN_CYC) + 1;
  logic [1:0] state;
  logic [DW-1:0] drain_cnt;
  logic [WIDTH+1:0] instr_q;
  logic [ZEROS_W-1:0] gold_q;
  logic instr_empty, gold_empty, instr_re, gold_re, launch;
  assign launch   = (state == S_IDLE || state == S_DONE) && start;
  assign instr_re = (state == S_RUN) && !instr_empty;
  assign gold_re  = ovalid && !gold_empty;
  assign busy     = state == S_RUN || state == S_DRAIN;
  assign done     = state == S_DONE;
  sync_fifo #(.WIDTH(WIDTH + 2), .DEPTH(DEPTH)) u_instr_fifo (
    .clk(clk), .rst_n(rst_n), .we(instr_we), .wdata(instr_in), .re(instr_re),
    .rdata(instr_q), .full(instr_full), .empty(instr_empty)
  );
  sync_fifo #(.WIDTH(ZEROS_W), .DEPTH(DEPTH)) u_gold_fifo (
    .clk(clk), .rst_n(rst_n), .we(gold_we), .wdata(gold_in), .re(gold_re),
    .rdata(gold_q), .full(gold_full), .empty(gold_empty)
  );
  // run sequencing: RUN until the instruction FIFO runs dry, then a fixed drain before DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
    end else if (launch) begin
      state <= S_RUN;
    end else if (state == S_RUN && instr_empty) begin
      state     <= S_DRAIN;
      drain_cnt <= '0;
    end else if (state == S_DRAIN) begin
      drain_cnt <= drain_cnt + 1'b1;
      if (drain_cnt == DW'(DRAIN_CYC - 1)) state <= S_DONE;
    end
  // registered LZC drive; mode/data hold between pops so only ivalid qualifies them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ivalid <= 1'b0;
      mode   <= 1'b0;
      data   <= '0;
    end else begin
      ivalid <= instr_re && instr_q[IV_BIT];
      if (instr_re) begin
        mode <= instr_q[MODE_BIT];
        data <= instr_q[WIDTH-1:0];
      end
    end
  // result scoring runs in every state; a result with no golden value counts as a mismatch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      err          <= 1'b0;
    end else if (launch) begin
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      err          <= 1'b0;
    end else if (ovalid) begin
      if (gold_empty) begin
        err          <= 1'b1;
        mismatch_cnt <= sat_inc(mismatch_cnt);
      end else if (zeros == gold_q) begin
        match_cnt <= sat_inc(match_cnt);
      end else begin
        mismatch_cnt <= sat_inc(mismatch_cnt);
      end
    end
endmodule
